// File: rtl/grp_sum_pkg.sv
// grp_sum_pkg
//   Shared types, width helpers and constants for the group-sum accumulator
//   family (grp_sum_acc, grp_lane_sum and sibling DUTs).
//   - ovf_mode_e    : overflow handling mode (wrap or saturate)
//   - sum_w()       : width of an N-lane unsigned sum with no loss
//   - cnt_w()       : width of a beat counter that can hold 0..grp
//   - CNT_W_DEFAULT : o_cnt width for the default group size
package grp_sum_pkg;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_mode_e;

  localparam int unsigned GRP_DEFAULT   = 32'd3;
  localparam int unsigned CNT_W_DEFAULT = $clog2(GRP_DEFAULT + 32'd1);

  // Lossless width of the sum of n_lane unsigned values of iw bits each.
  function automatic int unsigned sum_w(input int unsigned n_lane,
                                        input int unsigned iw);
    return iw + $clog2(n_lane);
  endfunction

  // Width of a counter able to hold every value 0..grp inclusive.
  function automatic int unsigned cnt_w(input int unsigned grp);
    return $clog2(grp + 32'd1);
  endfunction

endpackage

// File: rtl/grp_lane_sum.sv
// grp_lane_sum
//   Purely combinational unsigned sum of N_LANE lanes of IW bits each.
//   The result is wide enough that no carry is ever lost.
//   Ports:
//     data_i : [N_LANE][IW] lane values
//     sum_o  : SUM_W-bit sum of all lanes
module grp_lane_sum
  import grp_sum_pkg::*;
#(
  parameter  int unsigned N_LANE = 32'd2,
  parameter  int unsigned IW     = 32'd4,
  localparam int unsigned SUM_W  = sum_w(N_LANE, IW)
) (
  input  logic [N_LANE-1:0][IW-1:0] data_i,
  output logic [SUM_W-1:0]          sum_o
);

  // Add every lane, each zero-extended to the full result width.
  always_comb begin
    sum_o = '0;
    for (int k = 0; k < int'(N_LANE); k++) begin
      sum_o = sum_o + SUM_W'(data_i[k]);
    end
  end

endmodule

// File: rtl/grp_sum_acc.sv
// grp_sum_acc
//   Sums N_LANE unsigned lanes per accepted beat and accumulates the sums over
//   a group of GRP beats (or fewer when i_last closes the group early). The
//   group total, its beat count and an overflow flag are presented on a
//   valid/ready output register with backpressure.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     i_valid/i_ready     : input beat handshake (i_ready combinational from o_ready)
//     i_data              : [N_LANE][IW] lane values
//     i_last              : accepted beat closes the group early
//     o_valid/o_ready     : group result handshake
//     o_data              : OW-bit group total
//     o_cnt               : number of beats in the reported group (1..GRP)
//     o_ovf               : total overflowed OW bits during the group
module grp_sum_acc
  import grp_sum_pkg::*;
#(
  parameter  int unsigned N_LANE = 32'd2,
  parameter  int unsigned IW     = 32'd4,
  parameter  int unsigned GRP    = 32'd3,
  parameter  int unsigned OW     = 32'd7,
  parameter  bit          SAT    = 1'b0,
  localparam int unsigned CNT_W  = cnt_w(GRP)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [N_LANE-1:0][IW-1:0] i_data,
  input  logic                      i_last,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [OW-1:0]             o_data,
  output logic [CNT_W-1:0]          o_cnt,
  output logic                      o_ovf
);

  localparam int unsigned SUM_W = sum_w(N_LANE, IW);
  localparam ovf_mode_e   MODE  = SAT ? OVF_SAT : OVF_WRAP;

  logic [SUM_W-1:0] beat_sum_s;
  logic [OW-1:0]    base_s;
  logic [OW:0]      sum_ext_s;
  logic [OW-1:0]    acc_new_s;
  logic             ovf_new_s;
  logic             first_s;
  logic             acc_fire_s;
  logic             out_fire_s;
  logic             complete_s;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OW-1:0]    acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             o_valid_q, o_valid_d;
  logic [OW-1:0]    o_data_q, o_data_d;
  logic [CNT_W-1:0] o_cnt_q, o_cnt_d;
  logic             o_ovf_q, o_ovf_d;

  grp_lane_sum #(
    .N_LANE (N_LANE),
    .IW     (IW)
  ) u_lane_sum (
    .data_i (i_data),
    .sum_o  (beat_sum_s)
  );

  // A new beat may enter whenever the output slot is free or being drained
  // in this same cycle; held low during reset.
  assign i_ready    = !rst && (!o_valid_q || o_ready);
  assign acc_fire_s = i_valid && i_ready;
  assign out_fire_s = o_valid_q && o_ready;
  assign complete_s = acc_fire_s && ((cnt_q == CNT_W'(GRP - 32'd1)) || i_last);

  // Accumulate this beat onto the running total with one spare carry bit.
  // The first beat of a group starts from zero rather than the old acc.
  always_comb begin
    first_s   = (cnt_q == '0);
    base_s    = first_s ? '0 : acc_q;
    sum_ext_s = {1'b0, base_s} + (OW + 32'd1)'(beat_sum_s);
    if (sum_ext_s[OW] && (MODE == OVF_SAT)) begin
      acc_new_s = '1;
    end else begin
      acc_new_s = sum_ext_s[OW-1:0];
    end
    ovf_new_s = (first_s ? 1'b0 : ovf_q) | sum_ext_s[OW];
  end

  // Next-state for accumulator and output register; both move on the same
  // edge so a completing beat can overwrite a result being drained.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_cnt_d   = o_cnt_q;
    o_ovf_d   = o_ovf_q;
    if (complete_s) begin
      cnt_d     = '0;
      acc_d     = '0;
      ovf_d     = 1'b0;
      o_valid_d = 1'b1;
      o_data_d  = acc_new_s;
      o_cnt_d   = cnt_q + CNT_W'(1);
      o_ovf_d   = ovf_new_s;
    end else begin
      if (acc_fire_s) begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = acc_new_s;
        ovf_d = ovf_new_s;
      end else begin
        cnt_d = cnt_q;
      end
      if (out_fire_s) begin
        o_valid_d = 1'b0;
      end else begin
        o_valid_d = o_valid_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_cnt_q   <= '0;
      o_ovf_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_cnt_q   <= o_cnt_d;
      o_ovf_q   <= o_ovf_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_cnt   = o_cnt_q;
  assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_grp_sum_acc.sv
// tb_grp_sum_acc
//   Self-checking bench for grp_sum_acc: a directed vector table on the
//   default configuration, hand-written sequences for overflow, reset and
//   GRP=1, and a randomized run against a transaction-level group model.
module tb_grp_sum_acc;

  logic            clk;
  logic            rst;
  logic            i_valid;
  logic [1:0][3:0] i_data;
  logic            i_last;
  logic            o_ready;

  logic            i_ready,  w6_i_ready, s6_i_ready, g1_i_ready;
  logic            o_valid,  w6_o_valid, s6_o_valid, g1_o_valid;
  logic [6:0]      o_data,   g1_o_data;
  logic [5:0]      w6_o_data, s6_o_data;
  logic [1:0]      o_cnt,    w6_o_cnt, s6_o_cnt;
  logic            g1_o_cnt;
  logic            o_ovf,    w6_o_ovf, s6_o_ovf, g1_o_ovf;

  int checks = 0;
  int errors = 0;

  grp_sum_acc u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_cnt(o_cnt), .o_ovf(o_ovf)
  );

  grp_sum_acc #(.OW(6), .SAT(1'b0)) u_w6 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(w6_i_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(w6_o_valid), .o_ready(1'b1),
    .o_data(w6_o_data), .o_cnt(w6_o_cnt), .o_ovf(w6_o_ovf)
  );

  grp_sum_acc #(.OW(6), .SAT(1'b1)) u_s6 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(s6_i_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(s6_o_valid), .o_ready(1'b1),
    .o_data(s6_o_data), .o_cnt(s6_o_cnt), .o_ovf(s6_o_ovf)
  );

  grp_sum_acc #(.GRP(1)) u_g1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(g1_i_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(g1_o_valid), .o_ready(1'b1),
    .o_data(g1_o_data), .o_cnt(g1_o_cnt), .o_ovf(g1_o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic       last;
    logic       rdy;
    logic       e_irdy;
    logic       e_ov;
    logic [6:0] e_data;
    logic [1:0] e_cnt;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(input logic v, input int a, input int b,
                              input logic last, input logic rdy,
                              input logic e_irdy, input logic e_ov,
                              input int e_data, input int e_cnt);
    row_t r;
    r.v = v; r.a = 4'(a); r.b = 4'(b); r.last = last; r.rdy = rdy;
    r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_data = 7'(e_data); r.e_cnt = 2'(e_cnt);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one row at the falling edge, check i_ready, then check outputs after the rising edge.
  task automatic apply_row(input row_t r);
    @(negedge clk);
    i_valid = r.v; i_data = {r.b, r.a}; i_last = r.last; o_ready = r.rdy;
    #1 chk("i_ready", 32'(i_ready), 32'(r.e_irdy));
    @(posedge clk);
    #1;
    chk("o_valid", 32'(o_valid), 32'(r.e_ov));
    if (r.e_ov) begin
      chk("o_data", 32'(o_data), 32'(r.e_data));
      chk("o_cnt",  32'(o_cnt),  32'(r.e_cnt));
      chk("o_ovf",  32'(o_ovf),  32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Group-level reference model state
  int  grp_total, grp_beats;
  bit  m_ov, m_ovf;
  int  m_data, m_cnt;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst i_ready", 32'(i_ready), 32'd0);
    chk("rst o_valid", 32'(o_valid), 32'd0);
    chk("rst o_data",  32'(o_data),  32'd0);
    chk("rst o_cnt",   32'(o_cnt),   32'd0);
    chk("rst o_ovf",   32'(o_ovf),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table on the default configuration
    tbl.push_back(mk(1, 1, 2, 0, 1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 3, 4, 0, 1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 5, 6, 0, 1, 1, 1, 21, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 2, 2, 1, 1, 1, 1,  6, 2));
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 1,  3, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 4, 5, 1, 1, 1, 1,  9, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,  0, 0));
    // Backpressure: result of 21 held for 5 cycles with i_ready low
    tbl.push_back(mk(1, 1, 2, 0, 0, 1, 0,  0, 0));
    tbl.push_back(mk(1, 3, 4, 0, 0, 1, 0,  0, 0));
    tbl.push_back(mk(1, 5, 6, 0, 0, 1, 1, 21, 3));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 9, 9, 0, 0, 0, 1, 21, 3));
    tbl.push_back(mk(1, 7, 0, 0, 1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1,  7, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,  0, 0));
    foreach (tbl[i]) apply_row(tbl[i]);

    // Reset mid-group discards the partial sum
    apply_row(mk(1, 7, 7, 0, 1, 1, 0, 0, 0));
    apply_row(mk(1, 7, 7, 0, 1, 1, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b1; i_data = {4'd7, 4'd7};
    #1 chk("mid rst i_ready", 32'(i_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid rst o_valid", 32'(o_valid), 32'd0);
    chk("mid rst o_data",  32'(o_data),  32'd0);
    chk("mid rst o_cnt",   32'(o_cnt),   32'd0);
    chk("mid rst o_ovf",   32'(o_ovf),   32'd0);
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    apply_row(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    apply_row(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
    apply_row(mk(1, 1, 0, 0, 1, 1, 1, 3, 3));
    apply_row(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));

    // Overflow: (15,15) x3 under wrap and saturate with OW=6
    do_reset();
    apply_row(mk(1, 15, 15, 0, 1, 1, 0,  0, 0));
    apply_row(mk(1, 15, 15, 0, 1, 1, 0,  0, 0));
    apply_row(mk(1, 15, 15, 0, 1, 1, 1, 90, 3));
    chk("wrap o_valid", 32'(w6_o_valid), 32'd1);
    chk("wrap o_data",  32'(w6_o_data),  32'd26);
    chk("wrap o_ovf",   32'(w6_o_ovf),   32'd1);
    chk("sat o_valid",  32'(s6_o_valid), 32'd1);
    chk("sat o_data",   32'(s6_o_data),  32'd63);
    chk("sat o_ovf",    32'(s6_o_ovf),   32'd1);
    apply_row(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));

    // GRP=1: every beat is its own group, back to back
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      apply_row(mk(1, k, k, 0, 1, 1, (k == 3), 12, 3));
      chk("g1 o_valid", 32'(g1_o_valid), 32'd1);
      chk("g1 o_data",  32'(g1_o_data),  32'(2 * k));
      chk("g1 o_cnt",   32'(g1_o_cnt),   32'd1);
    end
    apply_row(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    chk("g1 idle o_valid", 32'(g1_o_valid), 32'd0);

    // Randomized run against the group model (default configuration)
    do_reset();
    grp_total = 0; grp_beats = 0; m_ov = 0; m_ovf = 0; m_data = 0; m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r_rst, v, l, rd, exp_rdy, acc, ofire;
      int a, b;
      r_rst = ($urandom_range(0, 199) == 0);
      v     = ($urandom_range(0, 3) != 0);
      l     = ($urandom_range(0, 5) == 0);
      rd    = ($urandom_range(0, 2) != 0);
      a     = $urandom_range(0, 15);
      b     = $urandom_range(0, 15);
      @(negedge clk);
      rst = r_rst; i_valid = v; i_last = l; o_ready = rd;
      i_data = {4'(b), 4'(a)};
      exp_rdy = !r_rst && (!m_ov || rd);
      #1 chk("rnd i_ready", 32'(i_ready), 32'(exp_rdy));
      acc   = v && exp_rdy;
      ofire = m_ov && rd;
      @(posedge clk);
      #1;
      if (r_rst) begin
        grp_total = 0; grp_beats = 0; m_ov = 0;
      end else begin
        if (acc) begin
          grp_total += a + b;
          grp_beats++;
        end
        if (acc && (grp_beats == 3 || l)) begin
          m_ov = 1; m_data = grp_total % 128; m_cnt = grp_beats;
          m_ovf = (grp_total >= 128);
          grp_total = 0; grp_beats = 0;
        end else if (ofire) begin
          m_ov = 0;
        end
      end
      chk("rnd o_valid", 32'(o_valid), 32'(m_ov));
      if (m_ov) begin
        chk("rnd o_data", 32'(o_data), 32'(m_data));
        chk("rnd o_cnt",  32'(o_cnt),  32'(m_cnt));
        chk("rnd o_ovf",  32'(o_ovf),  32'(m_ovf));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
